// File: rtl/ctrl_seq_gen.sv
// Instruction-control sequencer: fetch/decode/dispatch FSM with an interrupt entry path,
// memory and four-phase I/O waits, a per-wait timeout, and a sticky error trap.
module ctrl_seq_gen #(
    parameter int unsigned OPW   = 6,
    parameter int unsigned N_ALU = 16,
    parameter int unsigned N_MEM = 16,
    parameter int unsigned N_IO  = 4,
    parameter int unsigned TMO   = 255,
    parameter int unsigned CNT_W = 16
) (
    input  logic             g_clk,
    input  logic             g_clr,
    input  logic             run,
    input  logic             i_pending,
    input  logic             i_odv,
    input  logic             d_odv,
    input  logic [OPW-1:0]   opcode,
    input  logic             hs_in,
    output logic             hs_out,
    output logic             fetch_req,
    output logic             mem_req,
    output logic             exec_stb,
    output logic             irq_ack,
    output logic             vec_ld,
    output logic [OPW-1:0]   op_q,
    output logic [3:0]       state_o,
    output logic [1:0]       err,
    output logic [CNT_W-1:0] instr_cnt
);

    localparam int unsigned LIM_ALU = N_ALU;
    localparam int unsigned LIM_MEM = N_ALU + N_MEM;
    localparam int unsigned LIM_IO  = N_ALU + N_MEM + N_IO;
    // Counter only needs to reach TMO-1: that value marks the TMO-th cycle in a wait state.
    localparam int unsigned WAIT_W  = (TMO > 1) ? $clog2(TMO) : 1;

    typedef enum logic [3:0] {
        StIdle   = 4'd0,
        StIrq1   = 4'd1,
        StIrq2   = 4'd2,
        StFetch  = 4'd3,
        StDecode = 4'd4,
        StExec   = 4'd5,
        StMemw   = 4'd6,
        StHsreq  = 4'd7,
        StHsack  = 4'd8,
        StTrap   = 4'd9
    } state_e;

    state_e            r_state;
    logic [OPW-1:0]    r_op;
    logic [1:0]        r_err;
    logic [CNT_W-1:0]  r_cnt;
    logic [WAIT_W-1:0] r_wait;
    logic              w_tmo;

    assign w_tmo = (r_wait == WAIT_W'(TMO - 1));

    // Every transition clears the wait counter, so each wait state starts counting at zero.
    always_ff @(posedge g_clk) begin
        if (g_clr) begin
            r_state <= StIdle;
            r_op    <= '0;
            r_err   <= '0;
            r_cnt   <= '0;
            r_wait  <= '0;
        end else begin
            r_wait <= r_wait + 1'b1;
            unique case (r_state)
                StIdle: begin
                    if (run) begin
                        r_state <= i_pending ? StIrq1 : StFetch;
                        r_wait  <= '0;
                    end
                end
                StIrq1: begin
                    r_state <= StIrq2;
                    r_wait  <= '0;
                end
                StIrq2: begin
                    r_state <= StFetch;
                    r_wait  <= '0;
                end
                StFetch: begin
                    if (i_odv) begin
                        r_op    <= opcode;
                        r_state <= StDecode;
                        r_wait  <= '0;
                    end else if (w_tmo) begin
                        r_state <= StTrap;
                        r_err   <= 2'b10;
                    end
                end
                StDecode: begin
                    r_wait <= '0;
                    if (32'(r_op) < LIM_ALU) begin
                        r_state <= StExec;
                    end else if (32'(r_op) < LIM_MEM) begin
                        r_state <= StMemw;
                    end else if (32'(r_op) < LIM_IO) begin
                        r_state <= StHsreq;
                    end else begin
                        r_state <= StTrap;
                        r_err   <= 2'b01;
                    end
                end
                StExec: begin
                    r_cnt   <= r_cnt + 1'b1;
                    r_state <= StIdle;
                    r_wait  <= '0;
                end
                StMemw: begin
                    if (d_odv) begin
                        r_cnt   <= r_cnt + 1'b1;
                        r_state <= StIdle;
                        r_wait  <= '0;
                    end else if (w_tmo) begin
                        r_state <= StTrap;
                        r_err   <= 2'b10;
                    end
                end
                StHsreq: begin
                    if (hs_in) begin
                        r_state <= StHsack;
                        r_wait  <= '0;
                    end else if (w_tmo) begin
                        r_state <= StTrap;
                        r_err   <= 2'b10;
                    end
                end
                StHsack: begin
                    if (!hs_in) begin
                        r_cnt   <= r_cnt + 1'b1;
                        r_state <= StIdle;
                        r_wait  <= '0;
                    end else if (w_tmo) begin
                        r_state <= StTrap;
                        r_err   <= 2'b10;
                    end
                end
                StTrap: begin
                    r_state <= StTrap;
                end
                default: begin
                    r_state <= StIdle;
                    r_wait  <= '0;
                end
            endcase
        end
    end

    // Requests and strobes decode from the registered state alone.
    assign fetch_req = (r_state == StFetch);
    assign mem_req   = (r_state == StMemw);
    assign hs_out    = (r_state == StHsreq);
    assign exec_stb  = (r_state == StExec);
    assign irq_ack   = (r_state == StIrq1);
    assign vec_ld    = (r_state == StIrq2);
    assign op_q      = r_op;
    assign state_o   = r_state;
    assign err       = r_err;
    assign instr_cnt = r_cnt;

endmodule

// File: tb/tb_ctrl_seq_gen.sv
// Directed bench for ctrl_seq_gen: default instance plus a CNT_W=4 instance sharing stimulus.
module tb_ctrl_seq_gen;

    logic        g_clk = 1'b0;
    logic        g_clr, run, i_pending, i_odv, d_odv, hs_in;
    logic [5:0]  opcode;
    logic        hs_out, fetch_req, mem_req, exec_stb, irq_ack, vec_ld;
    logic [5:0]  op_q;
    logic [3:0]  state_o;
    logic [1:0]  err;
    logic [15:0] instr_cnt;
    logic        hs_out4, fetch_req4, mem_req4, exec_stb4, irq_ack4, vec_ld4;
    logic [5:0]  op_q4;
    logic [3:0]  state_o4;
    logic [1:0]  err4;
    logic [3:0]  instr_cnt4;

    int checks = 0;
    int errors = 0;
    int n;

    always #5 g_clk = ~g_clk;

    ctrl_seq_gen dut (
        .g_clk(g_clk), .g_clr(g_clr), .run(run), .i_pending(i_pending), .i_odv(i_odv),
        .d_odv(d_odv), .opcode(opcode), .hs_in(hs_in), .hs_out(hs_out),
        .fetch_req(fetch_req), .mem_req(mem_req), .exec_stb(exec_stb), .irq_ack(irq_ack),
        .vec_ld(vec_ld), .op_q(op_q), .state_o(state_o), .err(err), .instr_cnt(instr_cnt)
    );

    ctrl_seq_gen #(.CNT_W(4)) dut4 (
        .g_clk(g_clk), .g_clr(g_clr), .run(run), .i_pending(i_pending), .i_odv(i_odv),
        .d_odv(d_odv), .opcode(opcode), .hs_in(hs_in), .hs_out(hs_out4),
        .fetch_req(fetch_req4), .mem_req(mem_req4), .exec_stb(exec_stb4), .irq_ack(irq_ack4),
        .vec_ld(vec_ld4), .op_q(op_q4), .state_o(state_o4), .err(err4), .instr_cnt(instr_cnt4)
    );

    task automatic tick();
        @(posedge g_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        g_clr = 1'b1;
        tick();
        g_clr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        g_clr = 1'b1; run = 1'b0; i_pending = 1'b0; i_odv = 1'b0; d_odv = 1'b0;
        hs_in = 1'b0; opcode = 6'd0;
        tick();
        tick();
        chk("rst_state", 32'(state_o), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_cnt", 32'(instr_cnt), 0);
        chk("rst_opq", 32'(op_q), 0);
        chk("rst_reqs", 32'({hs_out, fetch_req, mem_req, exec_stb, irq_ack, vec_ld}), 0);
        g_clr = 1'b0;
        tick();
        chk("idle_hold", 32'(state_o), 0);

        // ALU instruction, i_odv on the second FETCH cycle
        run = 1'b1; opcode = 6'd3;
        tick();
        chk("alu_fetch1", 32'({state_o, fetch_req}), 32'({4'd3, 1'b1}));
        tick();
        chk("alu_fetch2", 32'(state_o), 3);
        i_odv = 1'b1;
        tick();
        i_odv = 1'b0; run = 1'b0;
        chk("alu_decode", 32'({state_o, op_q}), 32'({4'd4, 6'd3}));
        tick();
        chk("alu_exec", 32'({state_o, exec_stb}), 32'({4'd5, 1'b1}));
        tick();
        chk("alu_idle", 32'({state_o, exec_stb}), 32'({4'd0, 1'b0}));
        chk("alu_cnt", 32'(instr_cnt), 1);
        tick();
        chk("alu_run_off", 32'(state_o), 0);

        // Interrupt entry, then memory op with d_odv on the fifth MEMW cycle
        do_reset();
        run = 1'b1; i_pending = 1'b1;
        tick();
        chk("irq1", 32'({state_o, irq_ack, vec_ld}), 32'({4'd1, 1'b1, 1'b0}));
        run = 1'b0; i_pending = 1'b0;
        tick();
        chk("irq2", 32'({state_o, irq_ack, vec_ld}), 32'({4'd2, 1'b0, 1'b1}));
        tick();
        chk("irq_fetch", 32'({state_o, vec_ld}), 32'({4'd3, 1'b0}));
        opcode = 6'd20; i_odv = 1'b1;
        tick();
        i_odv = 1'b0;
        tick();
        chk("mem_enter", 32'(state_o), 6);
        n = 0;
        for (int i = 0; i < 8; i++) begin
            if (mem_req) n++;
            d_odv = (n == 5);
            tick();
        end
        d_odv = 1'b0;
        chk("mem_req_cycles", 32'(n), 5);
        chk("mem_idle", 32'(state_o), 0);
        chk("mem_cnt", 32'(instr_cnt), 1);

        // Four-phase I/O handshake
        do_reset();
        run = 1'b1; opcode = 6'd34;
        tick();
        i_odv = 1'b1; run = 1'b0;
        tick();
        i_odv = 1'b0;
        tick();
        chk("hs_req", 32'({state_o, hs_out}), 32'({4'd7, 1'b1}));
        tick();
        chk("hs_req_hold", 32'({state_o, hs_out}), 32'({4'd7, 1'b1}));
        hs_in = 1'b1;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            if (i == 3) hs_in = 1'b0;
            tick();
            if (state_o == 4'd8) n++;
            if (i == 0) chk("hs_ack_out", 32'(hs_out), 0);
        end
        chk("hs_ack_cycles", 32'(n), 3);
        chk("hs_idle", 32'(state_o), 0);
        chk("hs_cnt", 32'(instr_cnt), 1);

        // FETCH timeout after 255 cycles, trap is sticky
        do_reset();
        run = 1'b1;
        tick();
        repeat (254) tick();
        chk("tmo_cycle255", 32'({state_o, err}), 32'({4'd3, 2'b00}));
        tick();
        chk("tmo_trap", 32'({state_o, err, fetch_req}), 32'({4'd9, 2'b10, 1'b0}));
        i_odv = 1'b1; d_odv = 1'b1; hs_in = 1'b1;
        repeat (3) tick();
        chk("tmo_sticky", 32'({state_o, err, instr_cnt}), 32'({4'd9, 2'b10, 16'd0}));
        i_odv = 1'b0; d_odv = 1'b0; hs_in = 1'b0;

        // i_odv on the 255th FETCH cycle wins over the timeout
        do_reset();
        run = 1'b1; opcode = 6'd3;
        tick();
        repeat (254) tick();
        i_odv = 1'b1; run = 1'b0;
        tick();
        i_odv = 1'b0;
        chk("tmo_edge_decode", 32'({state_o, err}), 32'({4'd4, 2'b00}));
        tick();
        tick();
        chk("tmo_edge_done", 32'({state_o, err, instr_cnt}), 32'({4'd0, 2'b00, 16'd1}));

        // Illegal opcode traps with err=01
        do_reset();
        run = 1'b1; opcode = 6'd40;
        tick();
        i_odv = 1'b1;
        tick();
        i_odv = 1'b0;
        tick();
        chk("ill_trap", 32'({state_o, err}), 32'({4'd9, 2'b01}));
        repeat (3) tick();
        chk("ill_sticky", 32'({state_o, err}), 32'({4'd9, 2'b01}));

        // Clear in the middle of HSREQ
        do_reset();
        chk("clr_from_trap", 32'({state_o, err}), 0);
        opcode = 6'd34;
        tick();
        i_odv = 1'b1; run = 1'b0;
        tick();
        i_odv = 1'b0;
        tick();
        tick();
        chk("clr_pre_hs", 32'({state_o, hs_out}), 32'({4'd7, 1'b1}));
        g_clr = 1'b1;
        tick();
        g_clr = 1'b0;
        chk("clr_mid_hs", 32'({state_o, hs_out, err, op_q}), 0);

        // 16 ALU instructions: 4-bit counter wraps to zero
        do_reset();
        run = 1'b1; i_odv = 1'b1; opcode = 6'd5;
        n = 0;
        for (int i = 0; i < 64; i++) begin
            tick();
            if (exec_stb) n++;
            if (i == 59) chk("wrap_cnt15", 32'(instr_cnt4), 15);
        end
        run = 1'b0; i_odv = 1'b0;
        chk("wrap_exec_pulses", 32'(n), 16);
        chk("wrap_cnt16_wide", 32'(instr_cnt), 16);
        chk("wrap_cnt4_zero", 32'({state_o4, instr_cnt4}), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ctrl_seq_gen.md
CTRL_SEQ_GEN -- requirements
Module: ctrl_seq_gen

Interface
REQ-001 SHALL have parameter OPW, default 6, opcode width.
REQ-002 SHALL have parameter N_ALU, default 16, count of ALU opcodes (0..N_ALU-1).
REQ-003 SHALL have parameter N_MEM, default 16, count of memory opcodes, following the ALU opcodes.
REQ-004 SHALL have parameter N_IO, default 4, count of I/O-handshake opcodes, following the memory opcodes.
REQ-005 SHALL have parameter TMO, default 255, maximum number of cycles spent in any wait state.
REQ-006 SHALL have parameter CNT_W, default 16, width of the retired-instruction counter.
REQ-007 SHALL have one clock and a synchronous, active-high reset: g_clk input 1, rising-edge clock; g_clr input 1, clear.
REQ-008 SHALL have these ports, one per line:
  run  input  1  sequencer enable.
  i_pending  input  1  interrupt pending.
  i_odv  input  1  instruction data valid.
  d_odv  input  1  memory data valid.
  opcode  input  OPW  instruction opcode, sampled with i_odv.
  hs_in  input  1  I/O handshake acknowledge.
  hs_out  output  1  I/O handshake request.
  fetch_req  output  1  instruction fetch request.
  mem_req  output  1  memory access request.
  exec_stb  output  1  one-cycle ALU execute strobe.
  irq_ack  output  1  interrupt acknowledge.
  vec_ld  output  1  load interrupt vector into PC.
  op_q  output  OPW  latched opcode.
  state_o  output  4  current state.
  err  output  2  sticky error: 01 illegal, 10 timeout.
  instr_cnt  output  CNT_W  retired-instruction count.

Function
REQ-009 SHALL encode the states as IDLE=0, IRQ1=1, IRQ2=2, FETCH=3, DECODE=4, EXEC=5, MEMW=6, HSREQ=7, HSACK=8 and TRAP=9, and SHALL drive the current state on state_o.
REQ-010 IDLE SHALL hold while run=0, SHALL go to IRQ1 when run=1 and i_pending=1, and SHALL otherwise go to FETCH.
REQ-011 IRQ1 SHALL assert irq_ack for exactly one cycle and then go to IRQ2.
REQ-012 IRQ2 SHALL assert vec_ld for exactly one cycle and then go to FETCH.
REQ-013 FETCH SHALL assert fetch_req; on i_odv=1 it SHALL load opcode into op_q on that edge and go to DECODE.
REQ-014 DECODE (one cycle) SHALL go to EXEC if op_q<N_ALU, to MEMW if op_q<N_ALU+N_MEM, to HSREQ if op_q<N_ALU+N_MEM+N_IO, and otherwise to TRAP with err set to 01.
REQ-015 EXEC SHALL assert exec_stb for one cycle, increment instr_cnt and return to IDLE.
REQ-016 MEMW SHALL assert mem_req until d_odv=1, then increment instr_cnt and return to IDLE.
REQ-017 HSREQ SHALL assert hs_out until hs_in=1, then go to HSACK; HSACK SHALL hold hs_out=0 until hs_in=0, then increment instr_cnt and return to IDLE (four-phase handshake).
REQ-018 Timeout: a wait counter SHALL clear on entry to FETCH, MEMW, HSREQ and HSACK; if the awaited event is absent on the TMO-th cycle in that state, the next state SHALL be TRAP with err set to 10.
REQ-019 When the awaited event and the timeout occur in the same cycle, the event SHALL win and no error SHALL be recorded.
REQ-020 TRAP SHALL deassert all request and strobe outputs, SHALL hold until g_clr, and SHALL keep err and instr_cnt frozen.
REQ-021 A run deassertion while in any non-IDLE state SHALL let the current instruction complete; the sequencer then SHALL hold in IDLE.
REQ-022 instr_cnt SHALL wrap from 2^CNT_W-1 to 0.
REQ-023 i_pending SHALL be sampled only in IDLE; interrupts SHALL never preempt an instruction.
REQ-024 All outputs SHALL be registered or decoded from the registered state only, with no input-to-output combinational path.

Reset
REQ-025 While g_clr=1 at a rising edge, state SHALL become IDLE, op_q, err and instr_cnt SHALL become 0, and every request/strobe output SHALL become 0, including during a pending handshake or wait.
REQ-026 The first cycle after reset release SHALL evaluate the REQ-010 transitions.

Verification
REQ-027 run=1, i_pending=0, opcode=3, i_odv on the second FETCH cycle -> FETCH,FETCH,DECODE,EXEC,IDLE; exec_stb pulses once; instr_cnt=1.
REQ-028 run=1, i_pending=1 -> irq_ack then vec_ld one cycle each, then FETCH; opcode=20 with d_odv after 5 cycles -> mem_req high 5 cycles; instr_cnt=1.
REQ-029 opcode=34 -> hs_out=1 until hs_in=1; hs_in held 3 cycles -> HSACK for 3 cycles, then IDLE; instr_cnt increments once.
REQ-030 TMO=255, no i_odv -> TRAP after 255 FETCH cycles with err=10; i_odv on cycle 255 instead -> DECODE with err=00.
REQ-031 opcode=40 -> TRAP with err=01, sticky; g_clr for one cycle mid-HSREQ -> hs_out=0, state IDLE, err=0.
REQ-032 CNT_W=4, 16 ALU instructions -> instr_cnt returns to 0.
